mul_share_arbiter: RTL and testbench

- Shares one combinational Multiplier (WORD_WIDTH x WORD_WIDTH -> 2*WORD_WIDTH) among NUM_REQ requesters, e.g. PE rows or tile-edge units.
- Round-robin arbitration; valid/ready handshake on every requester port and on the response port.
- Registers each product in a single-entry output slot, tagged with the requester index.
- Drives the multiplier's a/b inputs and takes its y output; the Multiplier instance sits outside this block.

---
 rtl/mul_share_arbiter.sv | 93 +++++++++
 tb/tb_mul_share_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin arbiter sharing one external multiplier among NUM_REQ requesters
module mul_share_arbiter #(
    parameter int WORD_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_b,
    output logic [WORD_WIDTH-1:0]         mul_a,
    output logic [WORD_WIDTH-1:0]         mul_b,
    input  logic [2*WORD_WIDTH-1:0]       mul_y,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [2*WORD_WIDTH-1:0]       rsp_y,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [15:0]                   op_count
);

    logic                    rsp_valid_q, rsp_valid_d;
    logic [2*WORD_WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [15:0]             op_count_q, op_count_d;

    logic                    any_valid;
    logic                    can_accept;
    logic                    fire;
    logic [ID_WIDTH-1:0]     grant;
    int                      idx;

    assign any_valid  = |req_valid;
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign fire       = any_valid && can_accept;

    // Scan from the farthest offset back to rr_ptr so the nearest valid index wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                grant = ID_WIDTH'(idx);
            end
        end
    end

    assign req_ready = (fire && !reset) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant) : '0;
    assign mul_a     = any_valid ? req_a[int'(grant)*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign mul_b     = any_valid ? req_b[int'(grant)*WORD_WIDTH +: WORD_WIDTH] : '0;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;
        op_count_d  = op_count_q;
        if (fire) begin
            rsp_valid_d = 1'b1;
            rsp_y_d     = mul_y;
            rsp_id_d    = grant;
            rr_ptr_d    = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + ID_WIDTH'(1);
            op_count_d  = op_count_q + 16'd1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a, req_b;
    logic [W-1:0]    mul_a, mul_b;
    logic [2*W-1:0]  mul_y;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [2*W-1:0]  rsp_y;
    logic [IW-1:0]   rsp_id;
    logic [15:0]     op_count;

    logic [W-1:0]    ra [N];
    logic [W-1:0]    rb [N];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr;
    bit          m_valid;
    logic [15:0] m_y;
    int          m_id;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_a[g*W +: W] = ra[g];
        assign req_b[g*W +: W] = rb[g];
    end

    // External multiplier
    assign mul_y = mul_a * mul_b;

    mul_share_arbiter #(.WORD_WIDTH(W), .NUM_REQ(N), .ID_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_id(rsp_id), .op_count(op_count)
    );

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        g = model_grant();
        if (reset || g < 0 || !(!m_valid || rsp_ready)) return '0;
        return N'(1) << g;
    endfunction

    // Advance the model across one rising edge; inputs change 1ns after the edge.
    task automatic model_tick();
        int g;
        bit fire;
        g    = model_grant();
        fire = (g >= 0) && (!m_valid || rsp_ready);
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_valid = 0; m_y = 0; m_id = 0; m_cnt = 0;
        end else if (fire) begin
            m_y     = 16'(ra[g]) * 16'(rb[g]);
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % N;
            m_cnt   = m_cnt + 16'd1;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1; req_valid = '0; rsp_ready = 1;
        model_tick();
        model_tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; req_valid = 4'b1111; rsp_ready = 1;
        for (int i = 0; i < N; i++) begin ra[i] = 8'(i + 3); rb[i] = 8'(i + 5); end
        model_tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        model_tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_y !== 16'd0 || rsp_id !== 2'd0 || op_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b y=%0d id=%0d cnt=%0d want 0 0 0 0", rsp_valid, rsp_y, rsp_id, op_count);
        end
        reset = 0; req_valid = '0;
        model_tick();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100; ra[2] = 8'd23; rb[2] = 8'd37; rsp_ready = 1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100 || mul_a !== 8'd23 || mul_b !== 8'd37) begin
            errors++;
            $display("FAIL single_grant: got ready=%b a=%0d b=%0d want 0100 23 37", req_ready, mul_a, mul_b);
        end
        model_tick();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_y !== 16'd851 || rsp_id !== 2'd2 || op_count !== 16'd1) begin
            errors++;
            $display("FAIL single_rsp: got v=%b y=%0d id=%0d cnt=%0d want 1 851 2 1", rsp_valid, rsp_y, rsp_id, op_count);
        end
    endtask

    task automatic test_fairness();
        int exp_g [6] = '{0, 1, 2, 3, 0, 1};
        int exp_y [6] = '{2, 6, 12, 20, 2, 6};
        do_reset();
        for (int i = 0; i < N; i++) begin ra[i] = 8'(i + 1); rb[i] = 8'(i + 2); end
        req_valid = 4'b1111; rsp_ready = 1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_y !== 16'(exp_y[c-1]) || rsp_id !== 2'(exp_g[c-1])) begin
                    errors++;
                    $display("FAIL fair_rsp[%0d]: got v=%b y=%0d id=%0d want 1 %0d %0d", c-1, rsp_valid, rsp_y, rsp_id, exp_y[c-1], exp_g[c-1]);
                end
            end
            if (c < 6) begin
                checks++;
                if (req_ready !== (4'b0001 << exp_g[c])) begin
                    errors++;
                    $display("FAIL fair_grant[%0d]: got %b want %b", c, req_ready, 4'b0001 << exp_g[c]);
                end
                model_tick();
            end
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] p1;
        do_reset();
        req_valid = 4'b0001; ra[0] = 8'd255; rb[0] = 8'd255; rsp_ready = 1;
        model_tick();
        req_valid = 4'b0010; ra[1] = 8'($urandom); rb[1] = 8'($urandom); rsp_ready = 0;
        p1 = 16'(ra[1]) * 16'(rb[1]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_y !== 16'd65025 || rsp_id !== 2'd0 || req_ready !== 4'b0000 || op_count !== 16'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b y=%0d id=%0d ready=%b cnt=%0d want 1 65025 0 0000 1", c, rsp_valid, rsp_y, rsp_id, req_ready, op_count);
            end
            model_tick();
        end
        rsp_ready = 1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release: got %b want 0010", req_ready); end
        model_tick();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_y !== p1 || rsp_id !== 2'd1 || op_count !== 16'd2) begin
            errors++;
            $display("FAIL bp_next: got v=%b y=%0d id=%0d cnt=%0d want 1 %0d 1 2", rsp_valid, rsp_y, rsp_id, op_count, p1);
        end
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        rsp_ready = 1;
        req_valid = 4'b0100; ra[2] = 8'd9; rb[2] = 8'd9;
        model_tick();
        req_valid = 4'b0010; ra[1] = 8'd4; rb[1] = 8'd6;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant1: got %b want 0010", req_ready); end
        model_tick();
        req_valid = 4'b1010; ra[3] = 8'd7; rb[3] = 8'd8;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3: got %b want 1000", req_ready); end
        model_tick();
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010 || rsp_y !== 16'd56 || rsp_id !== 2'd3) begin
            errors++;
            $display("FAIL wrap_after: got ready=%b y=%0d id=%0d want 0010 56 3", req_ready, rsp_y, rsp_id);
        end
        model_tick();
        req_valid = '0;
    endtask

    task automatic test_idle();
        do_reset();
        rsp_ready = 1;
        req_valid = 4'b0001; ra[0] = 8'd10; rb[0] = 8'd11;
        model_tick();
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== (c == 0) || mul_a !== 8'd0 || mul_b !== 8'd0 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL idle[%0d]: got v=%b a=%0d b=%0d ready=%b want %0d 0 0 0000", c, rsp_valid, mul_a, mul_b, req_ready, c == 0);
            end
            model_tick();
        end
        req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL idle_ptr: got %b want 0010", req_ready); end
        model_tick();
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 1;
        req_valid = 4'b0100; ra[2] = 8'd5; rb[2] = 8'd5;
        model_tick();
        rsp_ready = 0; req_valid = 4'b1111;
        model_tick();
        reset = 1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_during: got ready=%b v=%b want 0000 1", req_ready, rsp_valid);
        end
        model_tick();
        reset = 0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_y !== 16'd0 || op_count !== 16'd0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_after: got v=%b y=%0d cnt=%0d ready=%b want 0 0 0 0001", rsp_valid, rsp_y, op_count, req_ready);
        end
        model_tick();
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] exp_ready;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    ra[i] = 8'($urandom);
                    rb[i] = 8'($urandom);
                end
            end
            @(negedge clk);
            exp_ready = model_ready();
            checks++;
            if (req_ready !== exp_ready || rsp_valid !== m_valid || op_count !== m_cnt) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got ready=%b v=%b cnt=%0d want %b %b %0d", c, req_ready, rsp_valid, op_count, exp_ready, m_valid, m_cnt);
            end
            checks++;
            if (m_valid && (rsp_y !== m_y || rsp_id !== 2'(m_id))) begin
                errors++;
                $display("FAIL rand_data[%0d]: got y=%0d id=%0d want %0d %0d", c, rsp_y, rsp_id, m_y, m_id);
            end
            model_tick();
            req_valid = req_valid & ~exp_ready;
        end
        reset = 0; req_valid = '0;
    endtask

    initial begin
        reset = 1; req_valid = '0; rsp_ready = 0;
        m_ptr = 0; m_valid = 0; m_y = 0; m_id = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_pointer_wrap();
        test_idle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
